// File: rtl/pipelined_subtractor_pkg.sv
// Shared definitions for the pipelined subtractor and related ALU datapath blocks:
// the flag bundle and the block-count / prefix-depth derivations.
package pipelined_subtractor_pkg;

  typedef struct packed {
    logic zero;
    logic neg;
    logic ovf;
    logic bout;
  } alu_flags_t;

  function automatic int num_blocos_f(input int width, input int block);
    return width / block;
  endfunction

  function automatic int depth_f(input int num_blocos);
    return $clog2(num_blocos);
  endfunction

endpackage

// File: rtl/cs_block.sv
// Carry-select block: precomputes the block sum for both possible incoming carries.
module cs_block #(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] a_i,
  input  logic [BLOCK-1:0] b_i,
  output logic [BLOCK-1:0] sum0_o,
  output logic [BLOCK-1:0] sum1_o,
  output logic             c0_o,
  output logic             c1_o
);

  assign {c0_o, sum0_o} = {1'b0, a_i} + {1'b0, b_i};
  assign {c1_o, sum1_o} = {1'b0, a_i} + {1'b0, b_i} + (BLOCK + 1)'(1);

endmodule

// File: rtl/parallel_prefix_tree.sv
// Kogge-Stone prefix over per-block generate/propagate; c_o[i] is the carry out of block i.
module parallel_prefix_tree #(
  parameter int N     = 4,
  parameter int DEPTH = 2
) (
  input  logic [N-1:0] g_i,
  input  logic [N-1:0] p_i,
  input  logic         cin_i,
  output logic [N-1:0] c_o
);

  logic [N-1:0] g_lvl, p_lvl, g_nxt, p_nxt;

  // Folding cin into block 0's generate turns every group prefix into a true carry.
  // NOTE: every variable gets a full default at the top of always_comb, so no latch can be inferred.
  always_comb begin
    g_lvl    = g_i;
    p_lvl    = p_i;
    g_lvl[0] = g_i[0] | (p_i[0] & cin_i);
    g_nxt    = g_lvl;
    p_nxt    = p_lvl;
    for (int l = 0; l < DEPTH; l++) begin
      g_nxt = g_lvl;
      p_nxt = p_lvl;
      for (int i = (1 << l); i < N; i++) begin
        g_nxt[i] = g_lvl[i] | (p_lvl[i] & g_lvl[i-(1<<l)]);
        p_nxt[i] = p_lvl[i] & p_lvl[i-(1<<l)];
      end
      g_lvl = g_nxt;
      p_lvl = p_nxt;
    end
    c_o = g_lvl;
  end

endmodule

// File: rtl/sub_flag_gen.sv
// Stage-4 status flags derived from the selected difference and the operand sign bits.
module sub_flag_gen
  import pipelined_subtractor_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] diff_i,
  input  logic             a_msb_i,
  input  logic             b_msb_i,
  input  logic             cout_i,
  output alu_flags_t       flags_o
);

  always_comb begin
    flags_o.zero = (diff_i == '0);
    flags_o.neg  = diff_i[WIDTH-1];
    flags_o.ovf  = (a_msb_i != b_msb_i) && (diff_i[WIDTH-1] != a_msb_i);
    flags_o.bout = ~cout_i;
  end

endmodule

// File: rtl/pipelined_subtractor.sv
// Four-stage carry-select / parallel-prefix subtractor (a - b - bin) with flags and
// a single global valid/ready stall enable shared by every stage.
module pipelined_subtractor
  import pipelined_subtractor_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int NUM_BLOCOS = num_blocos_f(WIDTH, BLOCK);
  localparam int DEPTH      = depth_f(NUM_BLOCOS);

  if ((WIDTH % BLOCK) != 0 || NUM_BLOCOS < 2) begin : g_bad_params
    $error("pipelined_subtractor: WIDTH must be a multiple of BLOCK with at least two blocks");
  end

  logic adv, accept;

  logic                  s1_valid_q, s1_cin_q;
  logic [WIDTH-1:0]      s1_a_q, s1_bn_q;

  logic                  s2_valid_q, s2_cin_q, s2_a_msb_q, s2_b_msb_q;
  logic [WIDTH-1:0]      s2_sum0_q, s2_sum1_q, s2_sum0_d, s2_sum1_d;
  logic [NUM_BLOCOS-1:0] s2_g_q, s2_p_q, s2_c0_d, s2_c1_d;

  logic                  s3_valid_q, s3_cout_q, s3_a_msb_q, s3_b_msb_q;
  logic [WIDTH-1:0]      s3_sum0_q, s3_sum1_q;
  logic [NUM_BLOCOS-1:0] s3_sel_q, s3_sel_d, blk_carry;

  logic                  out_valid_q;
  logic [WIDTH-1:0]      diff_q, diff_d;
  alu_flags_t            flags_q, flags_d;

  // The whole pipe advances together; a full output slot blocks everything behind it.
  assign adv      = ~out_valid_q | out_ready;
  assign in_ready = adv;
  assign accept   = in_valid & adv;

  for (genvar blk = 0; blk < NUM_BLOCOS; blk++) begin : g_cs
    cs_block #(.BLOCK(BLOCK)) u_cs (
      .a_i    (s1_a_q[blk*BLOCK +: BLOCK]),
      .b_i    (s1_bn_q[blk*BLOCK +: BLOCK]),
      .sum0_o (s2_sum0_d[blk*BLOCK +: BLOCK]),
      .sum1_o (s2_sum1_d[blk*BLOCK +: BLOCK]),
      .c0_o   (s2_c0_d[blk]),
      .c1_o   (s2_c1_d[blk])
    );
  end

  parallel_prefix_tree #(.N(NUM_BLOCOS), .DEPTH(DEPTH)) u_prefix (
    .g_i   (s2_g_q),
    .p_i   (s2_p_q),
    .cin_i (s2_cin_q),
    .c_o   (blk_carry)
  );

  assign s3_sel_d = {blk_carry[NUM_BLOCOS-2:0], s2_cin_q};

  always_comb begin
    diff_d = '0;
    for (int blk = 0; blk < NUM_BLOCOS; blk++) begin
      diff_d[blk*BLOCK +: BLOCK] = s3_sel_q[blk] ? s3_sum1_q[blk*BLOCK +: BLOCK]
                                                 : s3_sum0_q[blk*BLOCK +: BLOCK];
    end
  end

  sub_flag_gen #(.WIDTH(WIDTH)) u_flags (
    .diff_i  (diff_d),
    .a_msb_i (s3_a_msb_q),
    .b_msb_i (s3_b_msb_q),
    .cout_i  (s3_cout_q),
    .flags_o (flags_d)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every stage samples
  // the previous stage's pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: datapath registers are reset as well as valid bits, so outputs read 0 after reset.
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_cin_q    <= 1'b0;
      s1_a_q      <= '0;
      s1_bn_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_cin_q    <= 1'b0;
      s2_a_msb_q  <= 1'b0;
      s2_b_msb_q  <= 1'b0;
      s2_sum0_q   <= '0;
      s2_sum1_q   <= '0;
      s2_g_q      <= '0;
      s2_p_q      <= '0;
      s3_valid_q  <= 1'b0;
      s3_cout_q   <= 1'b0;
      s3_a_msb_q  <= 1'b0;
      s3_b_msb_q  <= 1'b0;
      s3_sum0_q   <= '0;
      s3_sum1_q   <= '0;
      s3_sel_q    <= '0;
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      flags_q     <= '0;
    end else if (adv) begin
      s1_valid_q  <= accept;
      s1_cin_q    <= accept ? ~bin : 1'b0;
      s1_a_q      <= accept ? a : '0;
      s1_bn_q     <= accept ? ~b : '0;

      s2_valid_q  <= s1_valid_q;
      s2_cin_q    <= s1_cin_q;
      s2_a_msb_q  <= s1_a_q[WIDTH-1];
      s2_b_msb_q  <= ~s1_bn_q[WIDTH-1];
      s2_sum0_q   <= s2_sum0_d;
      s2_sum1_q   <= s2_sum1_d;
      s2_g_q      <= s2_c0_d;
      s2_p_q      <= s2_c0_d ^ s2_c1_d;

      s3_valid_q  <= s2_valid_q;
      s3_cout_q   <= blk_carry[NUM_BLOCOS-1];
      s3_a_msb_q  <= s2_a_msb_q;
      s3_b_msb_q  <= s2_b_msb_q;
      s3_sum0_q   <= s2_sum0_q;
      s3_sum1_q   <= s2_sum1_q;
      s3_sel_q    <= s3_sel_d;

      out_valid_q <= s3_valid_q;
      diff_q      <= diff_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = flags_q.bout;
  assign zero      = flags_q.zero;
  assign neg       = flags_q.neg;
  assign ovf       = flags_q.ovf;

endmodule

// File: tb/tb_pipelined_subtractor.sv
// Scoreboard bench for pipelined_subtractor: directed vectors, a stalled stream,
// a random valid/ready soak and a mid-flight asynchronous reset.
module tb_pipelined_subtractor;

  localparam int WIDTH = 32;
  localparam int BLOCK = 8;

  logic             clk = 1'b0;
  logic             rst_n, in_valid, in_ready, bin, out_valid, out_ready;
  logic             bout, zero, neg, ovf;
  logic [WIDTH-1:0] a, b, diff;

  pipelined_subtractor #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // flags packed as {zero, neg, ovf, bout}
  typedef struct packed {
    logic [31:0] diff;
    logic [3:0]  flags;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_pushed = 0;
  int   n_popped = 0;
  bit   rand_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] d, input logic z, input logic n,
                              input logic o, input logic bo);
    exp_t e;
    e.diff  = d;
    e.flags = {z, n, o, bo};
    return e;
  endfunction

  function automatic exp_t model(input logic [31:0] ta, input logic [31:0] tb, input logic tbin);
    logic [32:0] full;
    logic [31:0] d;
    full = {1'b0, ta} - {1'b0, tb} - 33'(tbin);
    d    = full[31:0];
    return mk(d, d == 32'd0, d[31], (ta[31] != tb[31]) && (d[31] != ta[31]), full[32]);
  endfunction

  function automatic logic [31:0] out_flags();
    return {28'd0, zero, neg, ovf, bout};
  endfunction

  task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic tbin,
                      input exp_t e);
    int waited = 0;
    a = ta; b = tb; bin = tbin; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 500) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    else begin
      sb_q.push_back(e);
      n_pushed++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; a = '0; b = '0; bin = 1'b0;
  endtask

  task automatic send_rand();
    logic [31:0] ta, tb;
    logic        tbin;
    ta = $urandom; tb = $urandom; tbin = 1'($urandom_range(0, 1));
    send(ta, tb, tbin, model(ta, tb, tbin));
  endtask

  task automatic drain();
    int cyc = 0;
    out_ready = 1'b1;
    while (sb_q.size() != 0 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    check("drain_empty", 32'(sb_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic latency_check();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("latency_early", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    check("latency_valid", 32'(out_valid), 32'd1);
  endtask

  // Monitor: pops on every output handshake and checks hold behaviour while stalled.
  initial begin
    bit          prev_stall = 1'b0;
    logic [31:0] prev_diff  = '0;
    logic [31:0] prev_flags = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!rst_n) prev_stall = 1'b0;
      else begin
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) check("unexpected_output", 32'(out_valid), 32'd0);
          else begin
            e = sb_q.pop_front();
            n_popped++;
            check("diff", diff, e.diff);
            check("flags", out_flags(), {28'd0, e.flags});
          end
        end
        if (out_valid && !out_ready) begin
          check("in_ready_stall", 32'(in_ready), 32'd0);
          if (prev_stall) begin
            check("hold_diff", diff, prev_diff);
            check("hold_flags", out_flags(), prev_flags);
          end
          prev_stall = 1'b1;
          prev_diff  = diff;
          prev_flags = out_flags();
        end else prev_stall = 1'b0;
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;
    rand_done = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", diff, 32'd0);
    check("rst_flags", out_flags(), 32'd0);
    #22 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic op with latency check
    send(32'd5, 32'd3, 1'b0, mk(32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0));
    latency_check();
    drain();

    // Directed boundaries, back to back
    send(32'h0000_0000, 32'h0000_0001, 1'b0, mk(32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1));
    send(32'h1234_5678, 32'h1234_5678, 1'b0, mk(32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0));
    send(32'h0000_0000, 32'h0000_0000, 1'b1, mk(32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1));
    send(32'h8000_0000, 32'h0000_0001, 1'b0, mk(32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0));
    send(32'h0100_0000, 32'h0000_0000, 1'b1, mk(32'h00FF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0));
    send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b1));
    send(32'h0001_0000, 32'h0000_0001, 1'b0, mk(32'h0000_FFFF, 1'b0, 1'b0, 1'b0, 1'b0));
    drain();

    // 16 back-to-back with a 4-cycle downstream stall
    fork
      for (int i = 0; i < 16; i++) send_rand();
      begin
        repeat (6) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        out_ready = 1'b1;
      end
    join
    drain();

    // Random valid / random ready soak
    fork
      begin
        for (int i = 0; i < 2000; i++) begin
          while ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
          send_rand();
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with operations in flight
    send(32'd100, 32'd1, 1'b0, model(32'd100, 32'd1, 1'b0));
    send(32'd200, 32'd2, 1'b0, model(32'd200, 32'd2, 1'b0));
    send(32'd300, 32'd3, 1'b0, model(32'd300, 32'd3, 1'b0));
    @(posedge clk); #3;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_diff", diff, 32'd0);
    check("async_rst_flags", out_flags(), 32'd0);
    n_pushed -= sb_q.size();
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    send(32'd7, 32'd2, 1'b0, mk(32'h0000_0005, 1'b0, 1'b0, 1'b0, 1'b0));
    latency_check();
    drain();

    check("pushed_vs_popped", 32'(n_popped), 32'(n_pushed));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
